// File: rtl/ready_source.sv
// Ready-pulse source: issues a one-cycle ready, then watches a TIMEOUT-cycle window for a request.
// Hit/timeout statistics counters are built only when READY_SOURCE_STATS_EN is defined.
module ready_source #(
  parameter int unsigned TIMEOUT = 10,
  parameter int unsigned GAP_W   = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [GAP_W-1:0] gap,
  input  logic             request,
  output logic             ready,
  output logic             hit,
  output logic             timeout,
  output logic             spurious,
  output logic             busy,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_READY,
    S_WAIT
  } state_e;

  // Window counter holds the index of the previous sampling edge (0 at E1).
  localparam logic [7:0] WIN_LAST = 8'(TIMEOUT - 1);

  state_e           state_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [7:0]       win_cnt_q;
  logic             ready_q;
  logic             hit_q;
  logic             timeout_q;
  logic             spurious_q;

  logic [GAP_W-1:0] gap_load;
  logic             win_hit;
  logic             win_expire;
  logic             win_close;

  assign gap_load   = (gap == '0) ? GAP_W'(1) : gap;
  assign win_hit    = (state_q == S_WAIT) && request;
  assign win_expire = (state_q == S_WAIT) && !request && (win_cnt_q == WIN_LAST);
  assign win_close  = win_hit || win_expire;

  // NOTE: clocked state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gap_cnt_q  <= '0;
      win_cnt_q  <= '0;
      ready_q    <= 1'b0;
      hit_q      <= 1'b0;
      timeout_q  <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      ready_q    <= 1'b0;
      hit_q      <= win_hit;
      timeout_q  <= win_expire;
      spurious_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          spurious_q <= request;
          if (en) begin
            state_q   <= S_GAP;
            gap_cnt_q <= gap_load;
          end
        end
        S_GAP: begin
          spurious_q <= request;
          if (!en) begin
            state_q <= S_IDLE;
          end else if (gap_cnt_q == GAP_W'(1)) begin
            state_q <= S_READY;
            ready_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        S_READY: begin
          // A request coinciding with the ready pulse itself is ignored.
          state_q   <= S_WAIT;
          win_cnt_q <= '0;
        end
        S_WAIT: begin
          if (win_close) begin
            if (en) begin
              state_q   <= S_GAP;
              gap_cnt_q <= gap_load;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            win_cnt_q <= win_cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready    = ready_q;
  assign hit      = hit_q;
  assign timeout  = timeout_q;
  assign spurious = spurious_q;
  assign busy     = (state_q != S_IDLE);

`ifdef READY_SOURCE_STATS_EN
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // NOTE: combinational blocks assign a default first so no latch can be inferred.
  always_comb begin
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (win_hit && !(&ok_cnt_q)) begin
      ok_cnt_d = ok_cnt_q + CNT_W'(1);
    end
    if (win_expire && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ok_cnt  = ok_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  assign ok_cnt  = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: doc/ready_source.md
READY_SOURCE -- requirements
Module: ready_source

Interface
REQ-001 Parameter TIMEOUT, default 10, meaning: request window length in cycles after a ready pulse (legal 1..255).
REQ-002 Parameter GAP_W, default 8, meaning: width of the gap configuration input.
REQ-003 Parameter CNT_W, default 16, meaning: width of the statistics counters.
REQ-004 clk  input  1  meaning: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  meaning: asynchronous active-low reset.
REQ-006 en  input  1  meaning: enable for issuing ready pulses.
REQ-007 gap  input  GAP_W  meaning: idle cycles between the end of one window and the next ready pulse; sampled on entry to GAP; 0 is treated as 1.
REQ-008 request  input  1  meaning: response from the downstream requester.
REQ-009 ready  output  1  meaning: registered single-cycle ready pulse.
REQ-010 hit  output  1  meaning: registered single-cycle pulse, request seen inside the window.
REQ-011 timeout  output  1  meaning: registered single-cycle pulse, window expired without request.
REQ-012 spurious  output  1  meaning: registered single-cycle pulse, request high while no window is open.
REQ-013 busy  output  1  meaning: state is not IDLE.
REQ-014 ok_cnt, err_cnt  output  CNT_W each  meaning: hit and timeout counts.

Function
REQ-015 The FSM SHALL have states IDLE, GAP, READY and WAIT, with busy = (state != IDLE).
REQ-016 IDLE -> GAP SHALL occur on the first edge with en=1; the gap counter SHALL load max(gap,1).
REQ-017 GAP SHALL decrement each cycle and go to READY on the edge where the count reaches 1, giving exactly max(gap,1) GAP cycles.
REQ-018 In READY, ready SHALL be 1 for exactly one cycle; the next state SHALL be WAIT with the window counter cleared.
REQ-019 Define E0 as the edge sampling ready=1; request SHALL be checked at edges E1..E(TIMEOUT).
REQ-020 The first request=1 at Ek (1<=k<=TIMEOUT) SHALL assert hit in the cycle after Ek, increment ok_cnt, and close the window.
REQ-021 If request=0 at all of E1..E(TIMEOUT), timeout SHALL assert in the cycle after E(TIMEOUT) and err_cnt SHALL increment.
REQ-022 A request=1 sampled at E0 SHALL NOT count as a hit.
REQ-023 After a window closes, the next state SHALL be GAP if en=1, else IDLE.
REQ-024 Clearing en during GAP SHALL return to IDLE on the next edge with no ready pulse; clearing en during READY/WAIT SHALL let the window complete.
REQ-025 request=1 sampled in IDLE or GAP SHALL assert spurious the following cycle without changing state or counters.
REQ-026 Counters SHALL saturate at all-ones and never wrap.
REQ-027 At most one of hit and timeout SHALL be high in any cycle.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, zero all counters, and drive ready, hit, timeout, spurious and busy to 0.
REQ-029 Reset asserted mid-window SHALL abort the window without a hit or timeout pulse.
REQ-030 The first ready pulse after reset release with en=1 SHALL occur after exactly 1 (IDLE) + max(gap,1) (GAP) cycles.

Configuration
REQ-031 With READY_SOURCE_STATS_EN defined, ok_cnt and err_cnt SHALL behave per REQ-020, REQ-021 and REQ-026.
REQ-032 Without READY_SOURCE_STATS_EN, ok_cnt and err_cnt SHALL be constant 0 and no counter flops SHALL be synthesized; all pulses are unchanged.

Verification
REQ-033 en=1, gap=3, request pulsed at E4 -> ready after 1+3 cycles, hit in the cycle after E4, ok_cnt=1.
REQ-034 en=1, gap=5, request held 0 -> timeout in the cycle after E10, err_cnt=1, next ready 5 GAP cycles later.
REQ-035 Request at E0 only, then at E10 -> no hit at E0, hit after E10; request at E11 instead -> timeout plus spurious.
REQ-036 gap=0 -> behaves as gap=1; en dropped during GAP -> IDLE, no ready pulse.
REQ-037 rst_n pulsed low at E5 with request at E6 -> no hit or timeout, counters 0, busy=0.
REQ-038 CNT_W=4, 20 hits -> ok_cnt holds at 15; macro undefined -> ok_cnt=err_cnt=0 throughout.
